// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and default operand width.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: ripple-carry subtract S - {0,D} (B inverted, carry-in 1),
// keeping the difference only when no borrow occurred (carry out = 1).
module div_sub_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             nb
);

  logic [WIDTH:0]   b_inv;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;

  assign b_inv    = ~{1'b0, d};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
    assign diff[i]    = s[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (s[i] & b_inv[i]) | (carry[i] & (s[i] ^ b_inv[i]));
  end

  assign nb = carry[WIDTH+1];

  // R < D always holds, so S < 2D and the kept difference fits in WIDTH bits.
  assign r_next = nb ? diff[WIDTH-1:0] : s[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one conditional subtract per clock,
// start/done handshake, registered results held until the next accepted start.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] r_next;
  logic             nb;

  assign s = {r, a[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .s      (s),
    .d      (d),
    .r_next (r_next),
    .nb     (nb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              a     <= dividend;
              d     <= divisor;
              r     <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          r <= r_next;
          a <= {a[WIDTH-2:0], nb};
          if (cnt == '0) begin
            quotient    <= {a[WIDTH-2:0], nb};
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of seq_restoring_divider at WIDTH=4.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.WIDTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endfunction

  // Issue one request, optionally pulse a second start 'inject' cycles into the run,
  // then check latency, busy width, held outputs, results and done width.
  task automatic run_div(input string name, input logic [3:0] dvd, input logic [3:0] dvs,
                         input logic [3:0] eq, input logic [3:0] er, input logic edz,
                         input int lat, input int inject,
                         input logic [3:0] alt_dvd, input logic [3:0] alt_dvs);
    logic [3:0] q_before, r_before;
    int k, busy_cnt;
    bit stable;
    q_before = quotient;
    r_before = remainder;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    k        = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    while (!done && k < 12) begin
      if (busy) busy_cnt++;
      if (quotient !== q_before || remainder !== r_before) stable = 1'b0;
      if (k == inject) begin
        dividend = alt_dvd;
        divisor  = alt_dvs;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    chk({name, " done_seen"}, int'(done), 1);
    chk({name, " latency"}, k, lat);
    chk({name, " busy_cycles"}, busy_cnt, lat);
    chk({name, " held_during_run"}, int'(stable), 1);
    chk({name, " quotient"}, int'(quotient), int'(eq));
    chk({name, " remainder"}, int'(remainder), int'(er));
    chk({name, " div_by_zero"}, int'(div_by_zero), int'(edz));
    chk({name, " busy_at_done"}, int'(busy), 0);
    tick();
    chk({name, " done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    vecs[0] = '{dvd: 4'd9,  dvs: 4'd4,  q: 4'd2,  r: 4'd1, dz: 1'b0, lat: 4};
    vecs[1] = '{dvd: 4'd15, dvs: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 4};
    vecs[2] = '{dvd: 4'd3,  dvs: 4'd5,  q: 4'd0,  r: 4'd3, dz: 1'b0, lat: 4};
    vecs[3] = '{dvd: 4'd15, dvs: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 4};
    vecs[4] = '{dvd: 4'd7,  dvs: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1, lat: 0};
    vecs[5] = '{dvd: 4'd0,  dvs: 4'd3,  q: 4'd0,  r: 4'd0, dz: 1'b0, lat: 4};
    vecs[6] = '{dvd: 4'd12, dvs: 4'd5,  q: 4'd2,  r: 4'd2, dz: 1'b0, lat: 4};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset quotient", int'(quotient), 0);
    chk("reset remainder", int'(remainder), 0);
    chk("reset div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
              vecs[i].dz, vecs[i].lat, -1, 4'd0, 4'd0);

    // Second start during RUN must be ignored; then a fresh request is honoured.
    run_div("ignore_in_run", 4'd8, 4'd3, 4'd2, 4'd2, 1'b0, 4, 1, 4'd14, 4'd2);
    run_div("fresh_after", 4'd14, 4'd2, 4'd7, 4'd0, 1'b0, 4, -1, 4'd0, 4'd0);

    // Reset at the second RUN edge abandons the division without a done pulse.
    dividend = 4'd13;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset quotient", int'(quotient), 0);
    chk("midreset remainder", int'(remainder), 0);
    chk("midreset div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (done) seen++;
        tick();
      end
      chk("midreset no_done", seen, 0);
    end
    run_div("after_reset", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 4, -1, 4'd0, 4'd0);

    // Exhaustive back-to-back sweep against a reference model.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [3:0] eq, er;
        if (y == 0) begin
          eq = 4'hF;
          er = 4'(x);
        end else begin
          eq = 4'(x / y);
          er = 4'(x % y);
        end
        run_div($sformatf("sweep %0d/%0d", x, y), 4'(x), 4'(y), eq, er, (y == 0),
                (y == 0) ? 0 : 4, -1, 4'd0, 4'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
